bnn_feature_loader: RTL and testbench

BNN_FEATURE_LOADER -- requirements
Module: bnn_feature_loader

---
 rtl/bnn_feature_loader_if.sv | 30 +++
 rtl/bnn_feature_loader.sv | 124 ++++++++++++
 tb/tb_bnn_feature_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_feature_loader_if.sv
// Host-side bundle for the BNN feature loader.
//   s_valid / s_ready / s_data : feature word stream from the host into the loader
//   m_valid / m_ready          : result handshake from the loader back to the host
//   m_class / m_err / m_seq    : captured class, out-of-range flag, inference sequence number
// Modports:
//   slave  - the loader side (consumes words, produces results)
//   master - the host side (produces words, consumes results)
interface bnn_feature_loader_if #(
  parameter int FEAT_BITS = 4,
  parameter int CLASS_W   = 3
);
  logic                 s_valid;
  logic                 s_ready;
  logic [FEAT_BITS-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [CLASS_W-1:0]   m_class;
  logic                 m_err;
  logic [7:0]           m_seq;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_class, m_err, m_seq
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_class, m_err, m_seq
  );
endinterface

// File: rtl/bnn_feature_loader.sv
// Serial-to-parallel feature loader and sequencer for a binarised classifier.
// Collects FEAT_CNT host words into a parallel vector, restarts the classifier
// with a one-cycle pulse, waits INFER_CYCLES cycles, captures the prediction,
// and hands it to the host with a valid/ready handshake and a sequence number.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-low reset
//   host       - slave modport: feature stream in, result stream out
//   features   - parallel feature vector to the classifier
//   bnn_rst    - active-high one-cycle restart pulse to the classifier
//   prediction - classifier result, sampled on the last RUN cycle
module bnn_feature_loader #(
  parameter int FEAT_CNT     = 12,
  parameter int FEAT_BITS    = 4,
  parameter int CLASS_CNT    = 6,
  parameter int INFER_CYCLES = 48
) (
  input  logic                            clk,
  input  logic                            rst,
  bnn_feature_loader_if.slave             host,
  output logic [FEAT_CNT*FEAT_BITS-1:0]   features,
  output logic                            bnn_rst,
  input  logic [$clog2(CLASS_CNT)-1:0]    prediction
);

  localparam int CLASS_W = $clog2(CLASS_CNT);
  localparam int WCNT_W  = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int CCNT_W  = (INFER_CYCLES > 1) ? $clog2(INFER_CYCLES) : 1;

  typedef enum logic [1:0] {LOAD, RUN, OUT} state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic [WCNT_W-1:0]             word_cnt;
  logic [CCNT_W-1:0]             cyc_cnt;
  logic [FEAT_CNT*FEAT_BITS-1:0] features_q;
  logic [CLASS_W-1:0]            m_class_q;
  logic                          m_err_q;
  logic [7:0]                    m_seq_q;

  logic accept;
  logic last_word;
  logic last_cyc;
  logic handshake;

  assign accept    = (state == LOAD) && host.s_valid;
  assign last_word = (word_cnt == WCNT_W'(FEAT_CNT - 1));
  assign last_cyc  = (cyc_cnt == CCNT_W'(INFER_CYCLES - 1));
  assign handshake = (state == OUT) && host.m_ready;

  // State register plus all datapath registers; the feature slice written is
  // selected by the word counter, so unwritten slices simply hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LOAD;
      word_cnt   <= '0;
      cyc_cnt    <= '0;
      features_q <= '0;
      m_class_q  <= '0;
      m_err_q    <= 1'b0;
      m_seq_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          if (accept) begin
            for (int i = 0; i < FEAT_CNT; i++) begin
              if (word_cnt == WCNT_W'(i)) begin
                features_q[i*FEAT_BITS +: FEAT_BITS] <= host.s_data;
              end
            end
            word_cnt <= last_word ? '0 : word_cnt + 1'b1;
          end
        end
        RUN: begin
          if (last_cyc) begin
            cyc_cnt   <= '0;
            m_class_q <= prediction;
            // Widen by one bit so a power-of-two CLASS_CNT still compares correctly.
            m_err_q   <= ({1'b0, prediction} >= (CLASS_W + 1)'(CLASS_CNT));
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        OUT: begin
          if (handshake) begin
            m_seq_q <= m_seq_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and state-decoded outputs. The restart pulse is the first
  // RUN cycle, identified by the cycle counter still being zero.
  always_comb begin
    state_nxt    = state;
    host.s_ready = 1'b0;
    host.m_valid = 1'b0;
    bnn_rst      = 1'b0;
    case (state)
      LOAD: begin
        host.s_ready = 1'b1;
        if (accept && last_word) state_nxt = RUN;
      end
      RUN: begin
        bnn_rst = (cyc_cnt == '0);
        if (last_cyc) state_nxt = OUT;
      end
      OUT: begin
        host.m_valid = 1'b1;
        if (handshake) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign features     = features_q;
  assign host.m_class = m_class_q;
  assign host.m_err   = m_err_q;
  assign host.m_seq   = m_seq_q;

endmodule

// File: tb/tb_bnn_feature_loader.sv
// Directed self-checking bench for bnn_feature_loader at default parameters.
// Each scenario task drives its own stimulus and checks against hand-computed
// expected values; the summary line reports the check and failure counts.
module tb_bnn_feature_loader;

  logic        clk;
  logic        rst;
  logic [47:0] features;
  logic        bnn_rst;
  logic [2:0]  prediction;

  int checks;
  int failures;

  bnn_feature_loader_if #(.FEAT_BITS(4), .CLASS_W(3)) host ();

  bnn_feature_loader dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host),
    .features   (features),
    .bnn_rst    (bnn_rst),
    .prediction (prediction)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge; inputs are changed and
  // outputs sampled here, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    host.s_valid = 1'b0;
    host.s_data  = 4'h0;
    host.m_ready = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    host.s_valid = 1'b1;
    host.s_data  = 4'h9;
    host.m_ready = 1'b1;
    prediction   = 3'd7;
    rst = 1'b0;
    step();
    checks++;
    if (host.s_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_s_ready got=%0b expected=1", host.s_ready);
    end
    checks++;
    if (host.m_valid !== 1'b0 || bnn_rst !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_valid_bnnrst got=%0b/%0b expected=0/0", host.m_valid, bnn_rst);
    end
    checks++;
    if (features !== 48'h0) begin
      failures++; $display("[TB] FAIL reset_features got=%h expected=0", features);
    end
    checks++;
    if (host.m_class !== 3'd0 || host.m_err !== 1'b0 || host.m_seq !== 8'd0) begin
      failures++; $display("[TB] FAIL reset_result got=%0d/%0b/%0d expected=0/0/0", host.m_class, host.m_err, host.m_seq);
    end
    rst = 1'b1;
    host.s_valid = 1'b0;
    host.m_ready = 1'b0;
  endtask

  task automatic test_load_run();
    int rst_pulses;
    int ready_low;
    int mv_off;
    int mv_cnt;
    logic [2:0] cls;
    logic       err;
    logic [7:0] seq;
    do_reset();
    host.m_ready = 1'b1;
    prediction   = 3'd3;
    cls = 3'd0; err = 1'b1; seq = 8'hFF;
    for (int k = 0; k < 12; k++) begin
      host.s_valid = 1'b1;
      host.s_data  = 4'(k + 1);
      step();
    end
    host.s_data = 4'hF;
    checks++;
    if (features !== 48'hCBA987654321) begin
      failures++; $display("[TB] FAIL load_features got=%h expected=cba987654321", features);
    end
    checks++;
    if (bnn_rst !== 1'b1) begin
      failures++; $display("[TB] FAIL load_bnn_rst_after_last got=%0b expected=1", bnn_rst);
    end
    rst_pulses = 0; ready_low = 0; mv_off = -1; mv_cnt = 0;
    for (int off = 0; off < 50; off++) begin
      if (off > 0) step();
      if (bnn_rst) rst_pulses++;
      if (!host.s_ready) ready_low++;
      if (host.m_valid) begin
        mv_cnt++; mv_off = off;
        cls = host.m_class; err = host.m_err; seq = host.m_seq;
      end
    end
    host.s_valid = 1'b0;
    checks++;
    if (rst_pulses != 1) begin
      failures++; $display("[TB] FAIL run_bnn_rst_pulses got=%0d expected=1", rst_pulses);
    end
    checks++;
    if (ready_low != 49) begin
      failures++; $display("[TB] FAIL run_s_ready_low_cycles got=%0d expected=49", ready_low);
    end
    checks++;
    if (mv_cnt != 1 || mv_off != 48) begin
      failures++; $display("[TB] FAIL run_m_valid_timing got=count %0d offset %0d expected=count 1 offset 48", mv_cnt, mv_off);
    end
    checks++;
    if (cls !== 3'd3 || err !== 1'b0 || seq !== 8'd0) begin
      failures++; $display("[TB] FAIL run_result got=%0d/%0b/%0d expected=3/0/0", cls, err, seq);
    end
    checks++;
    if (features !== 48'hCBA987654321) begin
      failures++; $display("[TB] FAIL run_features_hold got=%h expected=cba987654321", features);
    end
  endtask

  // Continues straight from test_load_run: measures a full inference period
  // with s_valid and m_ready held high.
  task automatic test_back_to_back();
    int mv_at;
    int back_at;
    logic [7:0] seq;
    logic [2:0] cls;
    prediction   = 3'd5;
    host.m_ready = 1'b1;
    mv_at = -1; back_at = -1; seq = 8'hFF; cls = 3'd0;
    for (int c = 0; c < 62; c++) begin
      if (host.m_valid) begin
        mv_at = c; seq = host.m_seq; cls = host.m_class;
      end
      if (c > 0 && host.s_ready && back_at < 0 && mv_at >= 0) back_at = c;
      if (c == 61) break;
      host.s_valid = 1'b1;
      host.s_data  = (c < 12) ? 4'(12 - c) : 4'hF;
      step();
    end
    host.s_valid = 1'b0;
    checks++;
    if (mv_at != 60 || back_at != 61) begin
      failures++; $display("[TB] FAIL b2b_period got=valid %0d load %0d expected=valid 60 load 61", mv_at, back_at);
    end
    checks++;
    if (seq !== 8'd1 || cls !== 3'd5) begin
      failures++; $display("[TB] FAIL b2b_second_result got=seq %0d class %0d expected=seq 1 class 5", seq, cls);
    end
    checks++;
    if (features !== 48'h123456789ABC) begin
      failures++; $display("[TB] FAIL b2b_features got=%h expected=123456789abc", features);
    end
  endtask

  task automatic test_hold_err();
    int stable;
    do_reset();
    host.m_ready = 1'b1;
    prediction   = 3'd7;
    for (int k = 0; k < 12; k++) begin
      host.s_valid = 1'b1;
      host.s_data  = 4'(k);
      step();
    end
    host.s_valid = 1'b0;
    for (int i = 0; i < 47; i++) step();
    checks++;
    if (host.m_valid !== 1'b0 || host.m_seq !== 8'd0) begin
      failures++; $display("[TB] FAIL hold_ready_outside_out got=valid %0b seq %0d expected=valid 0 seq 0", host.m_valid, host.m_seq);
    end
    host.m_ready = 1'b0;
    step();
    prediction = 3'd2;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (host.m_valid === 1'b1 && host.m_class === 3'd7 && host.m_err === 1'b1 && host.m_seq === 8'd0) stable++;
      step();
    end
    checks++;
    if (stable != 10) begin
      failures++; $display("[TB] FAIL hold_stable_cycles got=%0d expected=10", stable);
    end
    checks++;
    if (host.m_class !== 3'd7 || host.m_err !== 1'b1) begin
      failures++; $display("[TB] FAIL hold_err_capture got=%0d/%0b expected=7/1", host.m_class, host.m_err);
    end
    host.m_ready = 1'b1;
    host.s_valid = 1'b1;
    host.s_data  = 4'hE;
    step();
    host.s_valid = 1'b0;
    host.m_ready = 1'b0;
    checks++;
    if (host.m_valid !== 1'b0 || host.m_seq !== 8'd1 || host.s_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL hold_handshake got=valid %0b seq %0d ready %0b expected=0/1/1", host.m_valid, host.m_seq, host.s_ready);
    end
    checks++;
    if (features !== 48'hBA9876543210) begin
      failures++; $display("[TB] FAIL hold_word_on_handshake got=%h expected=ba9876543210", features);
    end
  endtask

  task automatic test_toggle();
    int k;
    do_reset();
    host.m_ready = 1'b1;
    prediction   = 3'd0;
    k = 0;
    for (int c = 0; c < 23; c++) begin
      if (c % 2 == 0) begin
        host.s_valid = 1'b1;
        host.s_data  = 4'(k + 2);
        k++;
      end else begin
        host.s_valid = 1'b0;
        host.s_data  = 4'hF;
      end
      step();
    end
    checks++;
    if (bnn_rst !== 1'b1 || host.s_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL toggle_run_entry got=bnn_rst %0b ready %0b expected=1/0", bnn_rst, host.s_ready);
    end
    checks++;
    if (features !== 48'hDCBA98765432) begin
      failures++; $display("[TB] FAIL toggle_features got=%h expected=dcba98765432", features);
    end
    host.s_valid = 1'b1;
    host.s_data  = 4'hF;
    for (int i = 0; i < 49; i++) step();
    host.s_valid = 1'b0;
    checks++;
    if (host.s_ready !== 1'b1 || features !== 48'hDCBA98765432) begin
      failures++; $display("[TB] FAIL toggle_ignore_run_out got=ready %0b features %h expected=1 dcba98765432", host.s_ready, features);
    end
  endtask

  task automatic test_mid_reset();
    int mv;
    do_reset();
    host.m_ready = 1'b1;
    prediction   = 3'd4;
    for (int k = 0; k < 6; k++) begin
      host.s_valid = 1'b1;
      host.s_data  = 4'hA;
      step();
    end
    checks++;
    if (features !== 48'h000000AAAAAA) begin
      failures++; $display("[TB] FAIL midload_partial got=%h expected=000000aaaaaa", features);
    end
    host.s_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (features !== 48'h0) begin
      failures++; $display("[TB] FAIL midload_cleared got=%h expected=0", features);
    end
    mv = 0;
    for (int k = 0; k < 12; k++) begin
      host.s_valid = 1'b1;
      host.s_data  = 4'(k + 1);
      if (host.m_valid) mv++;
      step();
    end
    host.s_valid = 1'b0;
    checks++;
    if (bnn_rst !== 1'b1 || features !== 48'hCBA987654321) begin
      failures++; $display("[TB] FAIL midload_reload got=bnn_rst %0b features %h expected=1 cba987654321", bnn_rst, features);
    end
    for (int i = 0; i < 48; i++) begin
      if (host.m_valid) mv++;
      step();
    end
    checks++;
    if (mv != 0 || host.m_valid !== 1'b1 || host.m_class !== 3'd4 || host.m_seq !== 8'd0) begin
      failures++; $display("[TB] FAIL midload_result got=early %0d valid %0b class %0d seq %0d expected=0/1/4/0", mv, host.m_valid, host.m_class, host.m_seq);
    end
    step();
    for (int k = 0; k < 12; k++) begin
      host.s_valid = 1'b1;
      host.s_data  = 4'h6;
      step();
    end
    host.s_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    mv = 0;
    for (int i = 0; i < 60; i++) begin
      if (host.m_valid) mv++;
      step();
    end
    checks++;
    if (mv != 0 || host.s_ready !== 1'b1 || features !== 48'h0 || host.m_seq !== 8'd0) begin
      failures++; $display("[TB] FAIL midrun_reset got=valid %0d ready %0b features %h seq %0d expected=0/1/0/0", mv, host.s_ready, features, host.m_seq);
    end
  endtask

  task automatic test_seq_wrap();
    int pulses;
    logic [7:0] seq256;
    logic [7:0] seq257;
    do_reset();
    host.m_ready = 1'b1;
    host.s_valid = 1'b1;
    host.s_data  = 4'h5;
    prediction   = 3'd1;
    pulses = 0; seq256 = 8'h00; seq257 = 8'hFF;
    for (int c = 0; c < 257 * 61 + 200 && pulses < 257; c++) begin
      step();
      if (host.m_valid) begin
        pulses++;
        if (pulses == 256) seq256 = host.m_seq;
        if (pulses == 257) seq257 = host.m_seq;
      end
    end
    host.s_valid = 1'b0;
    step();
    checks++;
    if (pulses != 257) begin
      failures++; $display("[TB] FAIL wrap_inference_count got=%0d expected=257", pulses);
    end
    checks++;
    if (seq256 !== 8'd255 || seq257 !== 8'd0) begin
      failures++; $display("[TB] FAIL wrap_seq got=%0d,%0d expected=255,0", seq256, seq257);
    end
    checks++;
    if (host.m_seq !== 8'd1) begin
      failures++; $display("[TB] FAIL wrap_seq_after got=%0d expected=1", host.m_seq);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    host.s_valid = 1'b0;
    host.s_data  = 4'h0;
    host.m_ready = 1'b0;
    prediction   = 3'd0;
    checks   = 0;
    failures = 0;
    $display("[TB] starting bnn_feature_loader bench");
    test_reset();
    test_load_run();
    test_back_to_back();
    test_hold_err();
    test_toggle();
    test_mid_reset();
    test_seq_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
